// File: rtl/mult_pipe_ctrl_if.sv
// Handshake bundle between operand source, pipelined multiplier and result consumer.
// The master side is the environment (source + consumer); the slave side is the multiplier.
interface mult_pipe_ctrl_if #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned COUNT_W = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_x;
    logic [WIDTH-1:0]   in_y;
    logic               in_approx;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] out_p;
    logic               out_approx;
    logic [COUNT_W-1:0] op_count;

    modport master (
        output in_valid, in_x, in_y, in_approx, out_ready,
        input  in_ready, out_valid, out_p, out_approx, op_count
    );

    modport slave (
        input  in_valid, in_x, in_y, in_approx, out_ready,
        output in_ready, out_valid, out_p, out_approx, op_count
    );
endinterface

// File: rtl/mult_pipe_ctrl.sv
// Pipelined unsigned multiplier with valid/ready flow control, per-transaction exact or
// midpoint-compensated approximate mode, and a wrapping completed-operation counter.
module mult_pipe_ctrl #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned DROP_BITS   = 4,
    parameter int unsigned COUNT_W     = 16
) (
    input logic             clk,
    input logic             rst_n,
    mult_pipe_ctrl_if.slave bus
);
    localparam int unsigned PW = 2 * WIDTH;

    // Approximate operand = kept high bits, a one at the top dropped position, zeros below.
    localparam logic [WIDTH-1:0] KeepMask = {WIDTH{1'b1}} << DROP_BITS;
    localparam logic [WIDTH-1:0] OneBit   = WIDTH'(1);
    localparam logic [WIDTH-1:0] MidBit   = (OneBit << DROP_BITS) >> 1;

    logic                            en;
    logic                            out_fire;
    logic [WIDTH-1:0]                x_shaped;
    logic [WIDTH-1:0]                y_shaped;
    logic [PW-1:0]                   prod_in;

    logic [PIPE_STAGES-1:0]          vld_q;
    logic [PIPE_STAGES-1:0]          tag_q;
    logic [PIPE_STAGES-1:0][PW-1:0]  pr_q;

    logic [PIPE_STAGES-1:0]          vld_prev;
    logic [PIPE_STAGES-1:0]          tag_prev;
    logic [PIPE_STAGES-1:0][PW-1:0]  pr_prev;
    logic [PIPE_STAGES-1:0]          tag_d;
    logic [PIPE_STAGES-1:0][PW-1:0]  pr_d;

    logic [COUNT_W-1:0]              cnt_q;

    function automatic logic [WIDTH-1:0] shape_op(input logic [WIDTH-1:0] op,
                                                  input logic             approx);
        return approx ? ((op & KeepMask) | MidBit) : op;
    endfunction

    // Whole pipe advances together; a full output slot with no taker freezes everything.
    assign en       = !vld_q[PIPE_STAGES-1] || bus.out_ready;
    assign out_fire = vld_q[PIPE_STAGES-1] && bus.out_ready;

    assign x_shaped = shape_op(bus.in_x, bus.in_approx);
    assign y_shaped = shape_op(bus.in_y, bus.in_approx);
    assign prod_in  = PW'(x_shaped) * PW'(y_shaped);

    // Predecessor view of each stage: stage 0 is fed by the input port.
    assign vld_prev = PIPE_STAGES'({vld_q, bus.in_valid});
    assign tag_prev = PIPE_STAGES'({tag_q, bus.in_approx});
    assign pr_prev  = (PIPE_STAGES * PW)'({pr_q, prod_in});

    // Bubbles move on but leave the payload untouched, so outputs hold their last value.
    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        assign pr_d[s]  = vld_prev[s] ? pr_prev[s]  : pr_q[s];
        assign tag_d[s] = vld_prev[s] ? tag_prev[s] : tag_q[s];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            tag_q <= '0;
            pr_q  <= '0;
        end else if (en) begin
            vld_q <= vld_prev;
            tag_q <= tag_d;
            pr_q  <= pr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (out_fire) begin
            cnt_q <= cnt_q + COUNT_W'(1);
        end
    end

    assign bus.in_ready   = en;
    assign bus.out_valid  = vld_q[PIPE_STAGES-1];
    assign bus.out_p      = pr_q[PIPE_STAGES-1];
    assign bus.out_approx = tag_q[PIPE_STAGES-1];
    assign bus.op_count   = cnt_q;
endmodule
